master_rx_burst_port: RTL

Parametrised successor to the master-side receive port on the system bus. It deserialises the 1-bit slave-to-master data line into DATA_LEN-bit words for single or burst reads. Received words go into an internal show-ahead FIFO with a ready/valid consumer interface. When the FIFO is full, the block stalls the slave by dropping master_ready. Bit order is selectable.

---
 rtl/master_rx_pkg.sv | 17 +
 rtl/rx_word_fifo.sv | 52 +++++
 rtl/master_rx_burst_port.sv | 118 +++++++++++
 3 files changed

// File: rtl/master_rx_pkg.sv
// Shared encodings for the master-side serial receive port.
package master_rx_pkg;

  typedef enum logic [1:0] {
    INSTR_IDLE       = 2'b00,
    INSTR_WRITE      = 2'b01,
    INSTR_READ       = 2'b10,
    INSTR_BURST_READ = 2'b11
  } instr_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RX   = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/rx_word_fifo.sv
// Show-ahead word FIFO; the head output holds its last value while empty.
module rx_word_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last_q : mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_q + CW'(do_push) - CW'(do_pop);
      last_q <= head;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/master_rx_burst_port.sv
// Master receive port: deserialises slave bits into words for single/burst reads.
module master_rx_burst_port
  import master_rx_pkg::*;
#(
  parameter int unsigned DATA_LEN   = 8,
  parameter int unsigned BURST_LEN  = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MSB_FIRST  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_done,
  input  logic [1:0]           instruction,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic                 rx_data,
  input  logic                 slave_valid,
  output logic                 master_ready,
  output logic [DATA_LEN-1:0]  data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 new_rx,
  output logic                 rx_done,
  output logic                 busy
);

  localparam int unsigned BIT_W = $clog2(DATA_LEN);

  state_e               state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BURST_LEN-1:0] word_cnt_q, word_cnt_d;
  logic [DATA_LEN-1:0]  shift_q, shift_d;
  logic                 new_rx_q, new_rx_d;
  logic                 rx_done_q, rx_done_d;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 xfer;
  logic                 word_end;

  assign master_ready = (state_q == RX) && !fifo_full;
  assign xfer         = slave_valid && master_ready;
  assign word_end     = xfer && (bit_cnt_q == BIT_W'(DATA_LEN - 1));
  assign data_valid   = !fifo_empty;
  assign new_rx       = new_rx_q;
  assign rx_done      = rx_done_q;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      new_rx_q   <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      new_rx_q   <= new_rx_d;
      rx_done_q  <= rx_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    new_rx_d   = 1'b0;
    rx_done_d  = 1'b0;

    // The push uses shift_d so the bit arriving on this edge is included.
    if (xfer) begin
      if (MSB_FIRST != 0) shift_d = {shift_q[DATA_LEN-2:0], rx_data};
      else                shift_d = {rx_data, shift_q[DATA_LEN-1:1]};
      bit_cnt_d = word_end ? '0 : bit_cnt_q + BIT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tx_done && instruction[1]) begin
          word_cnt_d = ((instruction == INSTR_BURST_READ) && (burst_num != '0))
                       ? burst_num : BURST_LEN'(1);
          bit_cnt_d  = '0;
          state_d    = RX;
        end
      end
      RX: begin
        if (word_end) begin
          new_rx_d   = 1'b1;
          word_cnt_d = word_cnt_q - BURST_LEN'(1);
          if (word_cnt_q == BURST_LEN'(1)) state_d = DONE;
        end
      end
      DONE: begin
        rx_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  rx_word_fifo #(
    .WIDTH (DATA_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (word_end),
    .push_data (shift_d),
    .pop       (data_ready),
    .head      (data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
